seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Serial pattern transmitter; the stimulus end of the serial-bit sequence-detector interface.
- Drives the 1-bit serial line `x` that feeds `seqDet`.
- Loads a PAT_W-bit pattern and sends it MSB first, one bit per clock.
- Repeats the pattern a programmable number of times, with a programmable idle gap between repeats (0 = back-to-back, which exercises overlap).
- Frame and done flags give the bench and system exact alignment for checking `detect`.

Parameters:
- PAT_W, 4, pattern width in bits (≥2).
- CNT_W, 4, width of the repeat count.
- GAP_W, 3, width of the inter-frame gap length.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- abort  input  1  synchronous cancel; honoured in any non-IDLE state.
- pattern  input  PAT_W  bits to send; pattern[PAT_W-1] goes first.
- repeat_cnt  input  CNT_W  number of frames to send.
- gap_len  input  GAP_W  idle cycles between consecutive frames.
- x  output  1  serial data line to the detector.
- x_valid  output  1  high when x carries a pattern bit.
- frame_end  output  1  high during the last bit of each frame.
- busy  output  1  high from the first transmitted cycle through DONE.
- done  output  1  one-cycle pulse when all frames have been sent.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state←IDLE; x, x_valid, frame_end, busy, done all ←0; internal registers ←0. Reset may assert mid-frame and dominates everything.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - Outputs x=0, x_valid=0, busy=0.
  - When start=1 at an edge, capture pattern, repeat_cnt and gap_len.
  - If repeat_cnt≠0: go to SEND. The cycle after the capture edge shows x=pattern[PAT_W-1], x_valid=1, busy=1. This is 1-cycle latency from start to the first bit.
  - If repeat_cnt=0: go directly to DONE. No bits are sent and x_valid never rises.
- SEND:
  - Shift register moves left one bit per edge; x = shift MSB.
  - Bit counter runs PAT_W-1 down to 0; frame_end=1 when it is 0.
  - On the last bit, decrement the remaining-frames count.
  - If frames remain and gap≠0: go to GAP.
  - If frames remain and gap=0: reload the pattern and stay in SEND. The next cycle is the next frame's MSB, with no bubble.
  - If no frames remain: go to DONE.
- GAP:
  - x=0, x_valid=0, busy=1, held for exactly gap_len cycles.
  - Then reload the pattern and go to SEND.
- DONE:
  - One cycle with done=1, busy=1, x=0, x_valid=0.
  - Then go to IDLE. done is never high in any other state.
- Timing:
  - Total busy cycles = R·PAT_W + (R−1)·G + 1, with R=repeat_cnt, G=gap_len, R≥1.
  - For R=0, busy and done are each high for 1 cycle.
- start while not IDLE is ignored. Inputs are captured only at the start edge, so later changes to pattern, repeat_cnt or gap_len have no effect on the transfer in progress.
- abort=1 in SEND, GAP or DONE: the next state is IDLE, all outputs go to 0, and done is not pulsed.
- abort and start together in IDLE: start wins, because abort is ignored in IDLE.
- Counters:
  - Repeat count down-counts at CNT_W width and never wraps below 0.
  - Gap counter is GAP_W wide.
  - Maximum repeat_cnt = 2^CNT_W−1 frames.
- x is 0 whenever x_valid=0.

Test Plan:
- pattern=4'b1010, repeat_cnt=1, gap_len=0, start pulse → the cycle after start, x over 4 cycles = 1,0,1,0 with x_valid=1; frame_end on the 4th bit; done on the 5th cycle; busy high for 5 cycles.
- pattern=1010, repeat_cnt=3, gap_len=0 → 12 contiguous bits 101010101010; frame_end at bits 4, 8 and 12; done at cycle 13; the `seqDet` instance attached to x asserts detect for each overlapping match.
- pattern=1011, repeat_cnt=2, gap_len=2 → 1011, then 2 cycles of x=0/x_valid=0, then 1011; done at cycle 11.
- repeat_cnt=0, start → x_valid stays 0; busy and done are high for 1 cycle, the cycle after start; then IDLE.
- Transfer in progress (repeat_cnt=2), abort on the 2nd bit → next cycle x=0, x_valid=0, busy=0; done never asserts; a start pulse 3 cycles later sends a full fresh sequence.
- Assert reset low asynchronously mid-GAP (between clock edges) → all outputs go to 0 immediately without waiting for a clock edge. A start pulse issued while busy (before the reset) is ignored, and the sequence is not restarted.

Source files
------------

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first, repeated
// repeat_cnt times with gap_len idle cycles between frames, into a bit detector.
module seq_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             x,
  output logic             x_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             x_d, x_valid_d, frame_end_d, busy_d, done_d;

  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      frames_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      frames_q  <= frames_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      x         <= x_d;
      x_valid   <= x_valid_d;
      frame_end <= frame_end_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Outputs are computed for the state being entered, so each registered
  // output lines up with the state_q it belongs to.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frames_d    = frames_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    x_d         = 1'b0;
    x_valid_d   = 1'b0;
    frame_end_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d    = pattern;
          frames_d = repeat_cnt;
          gap_d    = gap_len;
          busy_d   = 1'b1;
          if (repeat_cnt != '0) begin
            state_d   = S_SEND;
            shift_d   = pattern;
            bit_cnt_d = LAST_IDX;
            x_d       = pattern[PAT_W-1];
            x_valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q != '0) begin
          shift_d     = shift_q << 1;
          bit_cnt_d   = bit_cnt_q - 1'b1;
          x_d         = shift_q[PAT_W-2];
          x_valid_d   = 1'b1;
          frame_end_d = (bit_cnt_q == BIT_W'(1));
          busy_d      = 1'b1;
        end else begin
          if (frames_q != '0) frames_d = frames_q - 1'b1;
          busy_d = 1'b1;
          if (frames_q > CNT_W'(1)) begin
            if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end else begin
              shift_d   = pat_q;
              bit_cnt_d = LAST_IDX;
              x_d       = pat_q[PAT_W-1];
              x_valid_d = 1'b1;
            end
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = S_SEND;
          shift_d   = pat_q;
          bit_cnt_d = LAST_IDX;
          gap_cnt_d = '0;
          x_d       = pat_q[PAT_W-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: per-cycle capture of all outputs compared
// against hand-derived waveforms for each scenario.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [3:0] repeat_cnt = '0;
  logic [2:0] gap_len = '0;
  logic       x, x_valid, frame_end, busy, done;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] cx, cv, cf, cb, cd;

  seq_gen #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .gap_len(gap_len),
    .x(x), .x_valid(x_valid), .frame_end(frame_end), .busy(busy),
    .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises start (inputs already set), then records n cycles of outputs;
  // the first recorded cycle ends up as the MSB of each n-bit window.
  task automatic capture(input int n);
    cx = '0; cv = '0; cf = '0; cb = '0; cd = '0;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      start = 1'b0;
      cx = {cx[30:0], x};
      cv = {cv[30:0], x_valid};
      cf = {cf[30:0], frame_end};
      cb = {cb[30:0], busy};
      cd = {cd[30:0], done};
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({x, x_valid, frame_end, busy, done} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {x, x_valid, frame_end, busy, done});
    end
    checks++;
    if (fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", fsm_state);
    end
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    pattern = 4'b1010; repeat_cnt = 4'd1; gap_len = 3'd0;
    capture(7);
    checks++;
    if (cx[6:0] !== 7'b1010000) begin errors++; $display("FAIL single_x: got %b expected 1010000", cx[6:0]); end
    checks++;
    if (cv[6:0] !== 7'b1111000) begin errors++; $display("FAIL single_valid: got %b expected 1111000", cv[6:0]); end
    checks++;
    if (cf[6:0] !== 7'b0001000) begin errors++; $display("FAIL single_frame_end: got %b expected 0001000", cf[6:0]); end
    checks++;
    if (cb[6:0] !== 7'b1111100) begin errors++; $display("FAIL single_busy: got %b expected 1111100", cb[6:0]); end
    checks++;
    if (cd[6:0] !== 7'b0000100) begin errors++; $display("FAIL single_done: got %b expected 0000100", cd[6:0]); end
  endtask

  task automatic test_back_to_back();
    pattern = 4'b1010; repeat_cnt = 4'd3; gap_len = 3'd0;
    capture(14);
    checks++;
    if (cx[13:0] !== 14'b10101010101000) begin errors++; $display("FAIL b2b_x: got %b expected 10101010101000", cx[13:0]); end
    checks++;
    if (cv[13:0] !== 14'b11111111111100) begin errors++; $display("FAIL b2b_valid: got %b expected 11111111111100", cv[13:0]); end
    checks++;
    if (cf[13:0] !== 14'b00010001000100) begin errors++; $display("FAIL b2b_frame_end: got %b expected 00010001000100", cf[13:0]); end
    checks++;
    if (cb[13:0] !== 14'b11111111111110) begin errors++; $display("FAIL b2b_busy: got %b expected 11111111111110", cb[13:0]); end
    checks++;
    if (cd[13:0] !== 14'b00000000000010) begin errors++; $display("FAIL b2b_done: got %b expected 00000000000010", cd[13:0]); end
  endtask

  task automatic test_gap();
    pattern = 4'b1011; repeat_cnt = 4'd2; gap_len = 3'd2;
    capture(12);
    checks++;
    if (cx[11:0] !== 12'b101100101100) begin errors++; $display("FAIL gap_x: got %b expected 101100101100", cx[11:0]); end
    checks++;
    if (cv[11:0] !== 12'b111100111100) begin errors++; $display("FAIL gap_valid: got %b expected 111100111100", cv[11:0]); end
    checks++;
    if (cf[11:0] !== 12'b000100000100) begin errors++; $display("FAIL gap_frame_end: got %b expected 000100000100", cf[11:0]); end
    checks++;
    if (cb[11:0] !== 12'b111111111110) begin errors++; $display("FAIL gap_busy: got %b expected 111111111110", cb[11:0]); end
    checks++;
    if (cd[11:0] !== 12'b000000000010) begin errors++; $display("FAIL gap_done: got %b expected 000000000010", cd[11:0]); end
  endtask

  task automatic test_zero_repeat();
    pattern = 4'b1111; repeat_cnt = 4'd0; gap_len = 3'd1;
    capture(3);
    checks++;
    if (cv[2:0] !== 3'b000) begin errors++; $display("FAIL zero_valid: got %b expected 000", cv[2:0]); end
    checks++;
    if (cx[2:0] !== 3'b000) begin errors++; $display("FAIL zero_x: got %b expected 000", cx[2:0]); end
    checks++;
    if (cb[2:0] !== 3'b100) begin errors++; $display("FAIL zero_busy: got %b expected 100", cb[2:0]); end
    checks++;
    if (cd[2:0] !== 3'b100) begin errors++; $display("FAIL zero_done: got %b expected 100", cd[2:0]); end
  endtask

  task automatic test_abort();
    logic saw_done;
    pattern = 4'b1100; repeat_cnt = 4'd2; gap_len = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({x, x_valid, busy} !== 3'b111) begin
      errors++; $display("FAIL abort_second_bit: got %b expected 111", {x, x_valid, busy});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({x, x_valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL abort_outputs: got %b expected 0000", {x, x_valid, busy, done});
    end
    checks++;
    if (fsm_state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", fsm_state); end
    saw_done = 1'b0;
    repeat (2) begin
      tick();
      saw_done = saw_done | done | busy;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %b expected 0", saw_done); end
    pattern = 4'b0110; repeat_cnt = 4'd1; gap_len = 3'd1;
    capture(6);
    checks++;
    if (cx[5:0] !== 6'b011000) begin errors++; $display("FAIL abort_restart_x: got %b expected 011000", cx[5:0]); end
    checks++;
    if (cv[5:0] !== 6'b111100) begin errors++; $display("FAIL abort_restart_valid: got %b expected 111100", cv[5:0]); end
    checks++;
    if (cd[5:0] !== 6'b000010) begin errors++; $display("FAIL abort_restart_done: got %b expected 000010", cd[5:0]); end
  endtask

  task automatic test_reset_mid_gap();
    logic [3:0] bits;
    logic       any_busy;
    pattern = 4'b1011; repeat_cnt = 4'd2; gap_len = 3'd3;
    start = 1'b1;
    tick();
    bits[3] = x;
    // Start and new operands mid-transfer must be ignored.
    pattern = 4'b0000; repeat_cnt = 4'd5; gap_len = 3'd0;
    tick();
    bits[2] = x;
    start = 1'b0;
    tick();
    bits[1] = x;
    tick();
    bits[0] = x;
    checks++;
    if (bits !== 4'b1011) begin errors++; $display("FAIL ignore_start_x: got %b expected 1011", bits); end
    checks++;
    if (frame_end !== 1'b1) begin errors++; $display("FAIL ignore_start_frame_end: got %b expected 1", frame_end); end
    tick();
    checks++;
    if ({x_valid, busy, fsm_state} !== 4'b0110) begin
      errors++; $display("FAIL in_gap: got %b expected 0110", {x_valid, busy, fsm_state});
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({x, x_valid, frame_end, busy, done} !== 5'b00000) begin
      errors++; $display("FAIL async_reset_outputs: got %b expected 00000", {x, x_valid, frame_end, busy, done});
    end
    checks++;
    if (fsm_state !== 2'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", fsm_state); end
    #2 reset = 1'b1;
    any_busy = 1'b0;
    repeat (4) begin
      tick();
      any_busy = any_busy | busy | x_valid | done;
    end
    checks++;
    if (any_busy !== 1'b0) begin errors++; $display("FAIL no_restart: got %b expected 0", any_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_zero_repeat();
    test_abort();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
